// File: rtl/multc.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Define MULTC_SIGNED_EN for two's-complement operands/result; otherwise operands are unsigned.
module multc #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned COEFWIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [COEFWIDTH-1:0]           a,
    input  logic [DATAWIDTH-1:0]           b,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATAWIDTH+COEFWIDTH-1:0] r,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned RW = DATAWIDTH + COEFWIDTH;
    localparam int unsigned CW = $clog2(COEFWIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [COEFWIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]        mcand_q, mcand_d;
    logic [RW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [RW-1:0]        r_q, r_d;
    logic                 out_valid_q, out_valid_d;

    logic [COEFWIDTH-1:0] a_mag;
    logic [DATAWIDTH-1:0] b_mag;
    logic                 sign_in;
    logic [RW-1:0]        acc_sum;
    logic                 accept;

`ifdef MULTC_SIGNED_EN
    // Magnitudes fit in W unsigned bits, including |-2^(W-1)|.
    assign a_mag   = a[COEFWIDTH-1] ? (~a + COEFWIDTH'(1)) : a;
    assign b_mag   = b[DATAWIDTH-1] ? (~b + DATAWIDTH'(1)) : b;
    assign sign_in = a[COEFWIDTH-1] ^ b[DATAWIDTH-1];
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign sign_in = 1'b0;
`endif

    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : RW'(0));
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) accept = 1'b1;
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(COEFWIDTH - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    r_d         = sign_q ? (RW'(0) - acc_sum) : acc_sum;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) accept = 1'b1;
                    else          state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Shared operand capture for IDLE and back-to-back DONE acceptance.
        if (accept) begin
            state_d  = S_RUN;
            mplier_d = a_mag;
            mcand_d  = RW'(b_mag);
            sign_d   = sign_in;
            acc_d    = RW'(0);
            cnt_d    = CW'(0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mplier_q    <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign r         = r_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multc.sv
// Scoreboard bench for multc (8x8); expected values follow the MULTC_SIGNED_EN setting.
module tb_multc;

    logic        clk;
    logic        reset;
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] r;
    logic        out_valid;
    logic        out_ready;

    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;
    logic [15:0] exp_q[$];

    multc #(.DATAWIDTH(8), .COEFWIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a_s),
        .b         (b_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(input logic [15:0] es, input logic [15:0] eu);
`ifdef MULTC_SIGNED_EN
        return es;
`else
        return eu;
`endif
    endfunction

    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb);
`ifdef MULTC_SIGNED_EN
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = 16'($signed(ma));
        sb = 16'($signed(mb));
        return 16'(sa * sb);
`else
        return 16'({8'h00, ma} * {8'h00, mb});
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_product actual=%h required=none", r);
                end else begin
                    chk("product", 32'(r), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk(name, 32'(in_ready), 32'd1);
    endtask

    // Issue one operation; optionally check exact latency and return to IDLE.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] te, input bit lat);
        @(negedge clk);
        a_s      = ta;
        b_s      = tb;
        in_valid = 1'b1;
        exp_q.push_back(te);
        wait_ready("accept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (lat) begin
            repeat (7) @(posedge clk);
            #1 chk("latency_early", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1 chk("latency_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1 chk("idle_ready", 32'(in_ready), 32'd1);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] bp_exp;
        int unsigned prev_cyc;
        int n;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset     = 1'b1;
        a_s       = '0;
        b_s       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_r", 32'(r), 32'd0);

        // Basic and sign/extreme directed vectors.
        run_op(8'h03, 8'h05, 16'h000F, 1'b1);
        run_op(8'hFF, 8'h7F, pick(16'hFF81, 16'h7E81), 1'b1);
        run_op(8'h80, 8'h80, pick(16'h4000, 16'h4000), 1'b1);
        run_op(8'h80, 8'h7F, pick(16'hC080, 16'h3F80), 1'b1);
        run_op(8'h00, 8'h80, 16'h0000, 1'b1);
        run_op(8'hFF, 8'hFF, pick(16'h0001, 16'hFE01), 1'b1);
        run_op(8'h80, 8'h02, pick(16'hFF00, 16'h0100), 1'b1);

        // Backpressure: result held, inputs ignored while stalled.
        out_ready = 1'b0;
        bp_exp    = pick(16'hFFEB, 16'h06EB);
        run_op(8'h07, 8'hFD, bp_exp, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_s      = 8'h11;
            b_s      = 8'h22;
            #1;
            chk("bp_r_stable", 32'(r), 32'(bp_exp));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_after_valid", 32'(out_valid), 32'd0);
        chk("bp_after_ready", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid and out_ready held high.
        prev_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            @(negedge clk);
            a_s      = ra;
            b_s      = rb;
            in_valid = 1'b1;
            exp_q.push_back(model(ra, rb));
            wait_ready("b2b_accept_timeout");
            @(posedge clk);
            if (i > 0) chk("b2b_interval", 32'(cyc - prev_cyc), 32'd9);
            prev_cyc = cyc;
        end
        #1 in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #3 chk("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Reset three cycles into RUN aborts the operation.
        @(negedge clk);
        a_s      = 8'h09;
        b_s      = 8'h09;
        in_valid = 1'b1;
        wait_ready("rst_accept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op(8'h02, 8'h03, 16'h0006, 1'b1);

        repeat (20) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
